serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 21 ++
 rtl/full_adder.sv | 19 +
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared types and helpers for the N-bit adder family.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    // Bit-counter width for an N-bit serial operation (never below one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial N-bit adder, LSB first, one full_adder cell with a
//                registered carry; start/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    serial_state_t state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fa_s;
    logic          fa_cout;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_cout;
                // New result bit enters at the MSB so bit 0 ends up at sum[0].
                sum_d   = (sum_q >> 1) | (N'(fa_s) << (N - 1));
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder with N = 4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int vectors;
    int miscompares;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[5];

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) begin
            miscompares++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation from a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                          output logic [N-1:0] osum, output logic ocout,
                          output int lat, output int bcnt);
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        lat = 0; bcnt = 0;
        while (!done && lat <= N + 4) begin
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        osum = sum; ocout = cout;
    endtask

    task automatic op_check(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                            input logic ic, input bit timing);
        logic [N-1:0] s;
        logic         co;
        logic [N:0]   exp;
        int           lat, bcnt;
        exp = {1'b0, ia} + {1'b0, ib} + {{N{1'b0}}, ic};
        run_op(ia, ib, ic, s, co, lat, bcnt);
        check({name, "_result"}, {27'd0, co, s}, {27'd0, exp});
        if (timing) begin
            check({name, "_latency"}, lat, N);
            check({name, "_busy_cycles"}, bcnt, N);
        end
        @(posedge clk);
        @(negedge clk);
        if (timing) begin
            check({name, "_done_one_cycle"}, {31'd0, done}, 0);
            check({name, "_sum_held"}, {28'd0, sum}, {28'd0, exp[N-1:0]});
        end
    endtask

    initial begin
        logic [N-1:0] s;
        logic         co;
        int           lat, bcnt, ndone, gap;
        bit           idle_seen;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        tbl[0] = '{a: 4'h5, b: 4'h3, cin: 1'b0, s: 4'h8, co: 1'b0};
        tbl[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, s: 4'h0, co: 1'b1};
        tbl[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, s: 4'hF, co: 1'b1};
        tbl[3] = '{a: 4'h0, b: 4'h0, cin: 1'b0, s: 4'h0, co: 1'b0};
        tbl[4] = '{a: 4'hA, b: 4'h5, cin: 1'b1, s: 4'h0, co: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum",  {28'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, lat, bcnt);
            check("tbl_sum", {28'd0, s}, {28'd0, tbl[i].s});
            check("tbl_cout", {31'd0, co}, {31'd0, tbl[i].co});
            check("tbl_latency", lat, N);
            check("tbl_busy_cycles", bcnt, N);
            @(posedge clk);
            @(negedge clk);
            check("tbl_done_pulse", {31'd0, done}, 0);
        end

        // Start during RUN is ignored
        start = 1'b1; a = 4'h2; b = 4'h2; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        start = 1'b1; a = 4'h7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) check("ignore_start_result", {27'd0, cout, sum}, 5'h04);
            end
            @(posedge clk); @(negedge clk);
        end
        check("ignore_start_single_done", ndone, 1);

        // Back-to-back with start held high
        start = 1'b1; a = 4'h1; b = 4'h1; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("b2b_first_result", {27'd0, cout, sum}, 5'h02);
        a = 4'h3; b = 4'h3;
        gap = 0; idle_seen = 1'b0;
        @(posedge clk); gap++; @(negedge clk);
        while (!done && gap < 10) begin
            if (!busy) idle_seen = 1'b1;
            @(posedge clk); gap++; @(negedge clk);
        end
        start = 1'b0;
        check("b2b_second_result", {27'd0, cout, sum}, 5'h06);
        check("b2b_done_spacing", gap, N + 1);
        check("b2b_no_idle", {31'd0, idle_seen}, 0);
        @(posedge clk); @(negedge clk);

        // Reset mid-RUN
        start = 1'b1; a = 4'h9; b = 4'h9; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_sum",  {28'd0, sum}, 0);
        check("rst_mid_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(posedge clk); @(negedge clk);
        end
        check("rst_mid_no_done", ndone, 0);
        op_check("post_reset", 4'h1, 4'h0, 1'b1, 1'b1);

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++)
            op_check("random", N'($urandom), N'($urandom), 1'($urandom), 1'b1);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++)
            op_check("exhaustive", i[3:0], i[7:4], i[8], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

endmodule : tb_serial_adder
`default_nettype wire
